// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use stall detection and
// EX-stage operand forwarding from the EX/MEM and MEM/WB writers.
// Optional build macro ILLEGAL_OP_TRAP_EN: when defined, unknown ALU opcodes
// are turned into bubbles and reported on the illegal_op pulse output; when
// undefined, opcodes pass through unchanged and illegal_op does not exist.
module id_ex_register #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [3:0]        id_alu_ctrl,
   input  logic              id_alu_src,
   input  logic [2:0]        id_wb_mem,
   input  logic              ex_hold,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [4:0]        exmem_rd,
   input  logic [DATA_W-1:0] exmem_data,
   input  logic              memwb_reg_write,
   input  logic [4:0]        memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_first,
   output logic [DATA_W-1:0] ex_second,
   output logic [3:0]        ex_control,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [4:0]        ex_rd,
   output logic [2:0]        ex_wb_mem
`ifdef ILLEGAL_OP_TRAP_EN
   ,
   output logic              illegal_op
`endif
);

   // Registered EX slot
   logic              valid_q,   valid_d;
   logic [4:0]        rs_q,      rs_d;
   logic [4:0]        rt_q,      rt_d;
   logic [4:0]        rd_q,      rd_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q,     imm_d;
   logic [3:0]        ctrl_q,    ctrl_d;
   logic              alu_src_q, alu_src_d;
   logic [2:0]        wb_mem_q,  wb_mem_d;
   logic              illegal_q, illegal_d;

   logic              trap_w;
   logic [DATA_W-1:0] fwd_b_w;

   // Pick the newest in-flight value for a source register; r0 is never forwarded.
   function automatic logic [DATA_W-1:0] forward_operand(
      input logic [4:0]        src,
      input logic [DATA_W-1:0] reg_val,
      input logic              em_we,
      input logic [4:0]        em_rd,
      input logic [DATA_W-1:0] em_data,
      input logic              mw_we,
      input logic [4:0]        mw_rd,
      input logic [DATA_W-1:0] mw_data
   );
      if (em_we && (em_rd != 5'd0) && (em_rd == src)) begin
         return em_data;
      end
      if (mw_we && (mw_rd != 5'd0) && (mw_rd == src)) begin
         return mw_data;
      end
      return reg_val;
   endfunction

`ifdef ILLEGAL_OP_TRAP_EN
   // Opcodes the ALU actually implements.
   function automatic logic opcode_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110,
         4'b0111, 4'b1000, 4'b1001, 4'b1010: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   assign trap_w     = id_valid & ~opcode_legal(id_alu_ctrl);
   assign illegal_op = illegal_q;
`else
   assign trap_w = 1'b0;
`endif

   // Load-use hazard: a load in EX targets a nonzero register that decode reads.
   assign id_stall = valid_q & wb_mem_q[1] & (rd_q != 5'd0)
                   & ((rd_q == id_rs) | (rd_q == id_rt)) & id_valid & ~flush;

   // Operand selection with forwarding, purely combinational from the slot.
   assign ex_first = forward_operand(rs_q, rs_data_q, exmem_reg_write, exmem_rd,
                                     exmem_data, memwb_reg_write, memwb_rd, memwb_data);
   assign fwd_b_w  = forward_operand(rt_q, rt_data_q, exmem_reg_write, exmem_rd,
                                     exmem_data, memwb_reg_write, memwb_rd, memwb_data);
   assign ex_second     = alu_src_q ? imm_q : fwd_b_w;
   assign ex_store_data = fwd_b_w;
   assign ex_valid      = valid_q;
   assign ex_control    = ctrl_q;
   assign ex_rd         = rd_q;
   assign ex_wb_mem     = wb_mem_q;

   // Next slot contents: flush beats hold, hold beats stall, stall beats load.
   always_comb begin
      valid_d   = valid_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      ctrl_d    = ctrl_q;
      alu_src_d = alu_src_q;
      wb_mem_d  = wb_mem_q;
      illegal_d = ~flush & ~ex_hold & ~id_stall & trap_w;
      if (flush || !ex_hold) begin
         if (flush || id_stall || !id_valid || trap_w) begin
            valid_d   = 1'b0;
            rs_d      = 5'd0;
            rt_d      = 5'd0;
            rd_d      = 5'd0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            ctrl_d    = 4'd0;
            alu_src_d = 1'b0;
            wb_mem_d  = 3'd0;
         end else begin
            valid_d   = 1'b1;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            ctrl_d    = id_alu_ctrl;
            alu_src_d = id_alu_src;
            wb_mem_d  = id_wb_mem;
         end
      end
   end

   // Slot registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         rs_q      <= 5'd0;
         rt_q      <= 5'd0;
         rd_q      <= 5'd0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         ctrl_q    <= 4'd0;
         alu_src_q <= 1'b0;
         wb_mem_q  <= 3'd0;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         ctrl_q    <= ctrl_d;
         alu_src_q <= alu_src_d;
         wb_mem_q  <= wb_mem_d;
         illegal_q <= illegal_d;
      end
   end

endmodule
